// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Two-requester UART transmit scheduler and serializer. Requesters A and B
//   share one serial TX line through round-robin arbitration. Each accepted
//   byte is sent as start bit, DBIT data bits LSB first, then the stop period.
//   Everything is timed by the 16x oversampling tick s_tick.
//
// Parameters
//   DBIT     data bits per frame (5..9)
//   SB_TICK  oversampling ticks in the stop period (16/24/32 = 1/1.5/2 stop bits)
//
// Optional build macro
//   UART_TX_PARITY_EN  inserts a 16-tick even-parity slot between data and stop.
//
// Ports
//   clk      in   system clock
//   reset    in   asynchronous, active-high reset
//   s_tick   in   one-clk-wide 16x baud tick
//   a_valid  in   requester A has a byte
//   a_data   in   requester A byte (DBIT)
//   a_ready  out  A byte accepted this cycle
//   b_valid  in   requester B has a byte
//   b_data   in   requester B byte (DBIT)
//   b_ready  out  B byte accepted this cycle
//   tx       out  serial line, idle high (registered)
//   busy     out  frame in progress
//   grant_b  out  owner of current/last frame: 0 = A, 1 = B
//
// Handshake: a byte transfers on a cycle where valid and ready are both high.
// Ready is combinational, asserted only in IDLE and only toward the selected
// requester. valid may rise or fall at any time; data is sampled only on the
// transfer cycle, and valid held during a frame waits until IDLE.

module uart_tx_sched #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            a_valid,
  input  logic [DBIT-1:0] a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [DBIT-1:0] b_data,
  output logic            b_ready,
  output logic            tx,
  output logic            busy,
  output logic            grant_b
);

  // The tick counter must hold both 15 (bit slots) and SB_TICK-1 (stop).
  localparam int TW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int BW = $clog2(DBIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            grant_q, grant_d;
`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  logic sel_a, sel_b, xfer;
  logic slot_end, stop_end, bit_last;

  assign slot_end = s_tick && (tick_q == TW'(15));
  assign stop_end = s_tick && (tick_q == TW'(SB_TICK - 1));
  assign bit_last = (bit_q == BW'(DBIT - 1));

  // Arbitration: a lone requester wins; under contention the one that did
  // not own the last frame wins, giving strict alternation.
  always_comb begin
    sel_a   = a_valid && (!b_valid || grant_q);
    sel_b   = b_valid && (!a_valid || !grant_q);
    a_ready = (state_q == S_IDLE) && sel_a && !reset;
    b_ready = (state_q == S_IDLE) && sel_b && !reset;
    xfer    = a_ready || b_ready;
  end

  // State register and all datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      grant_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      grant_q  <= grant_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (xfer) state_d = S_START;
      S_START: if (slot_end) state_d = S_DATA;
      S_DATA: begin
        if (slot_end && bit_last) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (slot_end) state_d = S_STOP;
`endif
      S_STOP:  if (stop_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic. tx_d is the level the line takes after the
  // coming edge, so tx changes on the same edge as the state or bit.
  always_comb begin
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    grant_d  = grant_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (xfer) begin
          shift_d  = a_ready ? a_data : b_data;
          grant_d  = b_ready;
          tick_d   = '0;
          tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = a_ready ? ^a_data : ^b_data;
`endif
        end
      end
      S_START: begin
        if (slot_end) begin
          tick_d = '0;
          bit_d  = '0;
          tx_d   = shift_q[0];
        end else if (s_tick) begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_DATA: begin
        if (slot_end) begin
          tick_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_last) begin
`ifdef UART_TX_PARITY_EN
            tx_d = parity_q;
`else
            tx_d = 1'b1;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
            // shift_q[1] becomes bit 0 after this shift.
            tx_d  = shift_q[1];
          end
        end else if (s_tick) begin
          tick_d = tick_q + TW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (slot_end) begin
          tick_d = '0;
          tx_d   = 1'b1;
        end else if (s_tick) begin
          tick_d = tick_q + TW'(1);
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (stop_end) tick_d = '0;
        else if (s_tick) tick_d = tick_q + TW'(1);
      end
      default: begin
        tx_d   = 1'b1;
        tick_d = '0;
      end
    endcase
  end

  assign tx      = tx_q;
  assign busy    = (state_q != S_IDLE);
  assign grant_b = grant_q;

endmodule
